pipe_elastic_lanes: RTL and testbench

- Parametrised successor to the fixed 16-lane pipeline register: LANES lanes of D_WIDTH bits, DEPTH register stages.
- Adds a valid/ready handshake with per-stage valid bits, bubble collapsing, synchronous flush and an occupancy count.
- Sits between butterfly/multiplier stages of the FFT datapath, where downstream back-pressure must stall the data without losing it.

---
 rtl/pipe_elastic_lanes.sv | 107 ++++++++++
 tb/tb_pipe_elastic_lanes.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic_lanes.sv
// Elastic multi-lane pipeline register with per-stage valid bits, bubble collapsing and flush.
// Latency: DEPTH cycles from in_data to out_data when out_ready stays high; 1 beat/cycle.
// Backpressure: ready ripples combinationally from out_ready to in_ready (no skid buffer).
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_data carries LANES*D_WIDTH packed lanes
//   out_valid/out_ready downstream handshake; out_data is the last stage register
//   flush               synchronous clear of all valid bits (data registers untouched)
//   occ_cnt             registered count of valid stages, 0..DEPTH
module pipe_elastic_lanes #(
  parameter int D_WIDTH = 64,
  parameter int LANES   = 16,
  parameter int DEPTH   = 1,
  parameter int CNT_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*D_WIDTH-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*D_WIDTH-1:0]   out_data,
  input  logic                       flush,
  output logic [CNT_W-1:0]           occ_cnt
);

  localparam int BW = LANES * D_WIDTH;

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [BW-1:0]    d_q   [DEPTH];
  logic [BW-1:0]    up_dat[DEPTH];
  logic [DEPTH-1:0] up_vld;
  logic [DEPTH-1:0] ld_en;
  logic [DEPTH-1:0] adv;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A stage may advance when it is empty or when everything downstream advances;
  // this is what lets an empty stage fill while later stages are stalled.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = ~v_q[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = ~v_q[i] | adv[i+1];
    end
  end

  assign in_ready = adv[0] & ~flush;

  // Upstream view of each stage: the input port for stage 0, the previous stage otherwise.
  always_comb begin
    up_vld    = '0;
    up_vld[0] = in_valid & in_ready;
    up_dat[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_vld[i] = v_q[i-1];
      up_dat[i] = d_q[i-1];
    end
  end

  // Data only loads on a real beat so bubbles never disturb the held payload.
  always_comb begin
    v_d   = v_q;
    ld_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        v_d[i] = 1'b0;
      end else if (adv[i]) begin
        v_d[i]   = up_vld[i];
        ld_en[i] = up_vld[i];
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + CNT_W'(v_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (ld_en[i]) begin
          d_q[i] <= up_dat[i];
        end
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occ_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_elastic_lanes.sv
// Directed bench for pipe_elastic_lanes across four parameter sets.
// Latency: n/a (testbench).
// Backpressure: drives out_ready directly on each instance.
module tb_pipe_elastic_lanes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   total = 0;
  int   bad   = 0;

  // A: DEPTH=3, 16 x 64-bit lanes
  logic          a_iv, a_ir, a_ov, a_or, a_fl;
  logic [1023:0] a_id, a_od;
  logic [3:0]    a_occ;
  pipe_elastic_lanes #(.D_WIDTH(64), .LANES(16), .DEPTH(3), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .flush(a_fl), .occ_cnt(a_occ));

  // B: DEPTH=4, bubble collapse
  logic        b_iv, b_ir, b_ov, b_or, b_fl;
  logic [31:0] b_id, b_od;
  logic [2:0]  b_occ;
  pipe_elastic_lanes #(.D_WIDTH(16), .LANES(2), .DEPTH(4), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .flush(b_fl), .occ_cnt(b_occ));

  // C: DEPTH=2, flush
  logic        c_iv, c_ir, c_ov, c_or, c_fl;
  logic [31:0] c_id, c_od;
  logic [1:0]  c_occ;
  pipe_elastic_lanes #(.D_WIDTH(16), .LANES(2), .DEPTH(2), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .flush(c_fl), .occ_cnt(c_occ));

  // D: DEPTH=1, 2 x 8-bit lanes, random traffic
  logic        d_iv, d_ir, d_ov, d_or, d_fl;
  logic [15:0] d_id, d_od;
  logic [1:0]  d_occ;
  pipe_elastic_lanes #(.D_WIDTH(8), .LANES(2), .DEPTH(1), .CNT_W(2)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id),
    .out_valid(d_ov), .out_ready(d_or), .out_data(d_od), .flush(d_fl), .occ_cnt(d_occ));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_l%0d", tag, k), obs[k*64 +: 64], exp[k*64 +: 64]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] beat(input int n);
    logic [1023:0] r;
    for (int k = 0; k < 16; k++) begin
      r[k*64 +: 64] = 64'h1000 + 64'(k) + 64'(n);
    end
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] q[$];
    logic [15:0] front;
    logic [31:0] bseq[4];
    int          seq;

    rst = 1'b0;
    a_iv = 0; a_or = 0; a_fl = 0; a_id = '0;
    b_iv = 0; b_or = 0; b_fl = 0; b_id = '0;
    c_iv = 0; c_or = 0; c_fl = 0; c_id = '0;
    d_iv = 0; d_or = 0; d_fl = 0; d_id = '0;

    // Asynchronous reset asserted before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_ov", 64'(a_ov), 64'd0);
    chk("rst_occ", 64'(a_occ), 64'd0);
    chk("rst_ir", 64'(a_ir), 64'd1);
    chk_bus("rst_dat", a_od, '0);
    chk("rst_ir_d", 64'(d_ir), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    tick();

    // Streaming, out_ready held high: beat t accepted at edge t, visible after edge t+2.
    a_or = 1'b1;
    for (int t = 0; t < 15; t++) begin
      int acc, gone;
      a_iv = (t < 10);
      a_id = beat(t);
      #1;
      if (t < 10) chk("stream_ir", 64'(a_ir), 64'd1);
      tick();
      acc  = (t + 1 < 10) ? t + 1 : 10;
      gone = (t - 2 < 0) ? 0 : ((t - 2 > 10) ? 10 : t - 2);
      chk($sformatf("stream_ov_t%0d", t), 64'(a_ov), 64'((t >= 2) && (t <= 11)));
      chk($sformatf("stream_occ_t%0d", t), 64'(a_occ), 64'(acc - gone));
      if ((t >= 2) && (t <= 11)) chk_bus($sformatf("stream_dat_t%0d", t), a_od, beat(t - 2));
    end

    // Back-pressure: fill A,B,C with out_ready low, then hold an extra beat upstream.
    a_or = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_iv = 1'b1;
      a_id = beat(100 * (i + 1));
      tick();
    end
    a_iv = 1'b1;
    a_id = beat(400);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ir", 64'(a_ir), 64'd0);
      chk("bp_occ", 64'(a_occ), 64'd3);
      chk("bp_ov", 64'(a_ov), 64'd1);
      chk_bus("bp_dat", a_od, beat(100));
      tick();
    end
    a_iv = 1'b0;
    a_or = 1'b1;
    #1;
    chk("bp_ir_rise", 64'(a_ir), 64'd1);
    tick();
    chk("drain_ov1", 64'(a_ov), 64'd1);
    chk("drain_occ1", 64'(a_occ), 64'd2);
    chk_bus("drain_b", a_od, beat(200));
    tick();
    chk("drain_ov2", 64'(a_ov), 64'd1);
    chk("drain_occ2", 64'(a_occ), 64'd1);
    chk_bus("drain_c", a_od, beat(300));
    tick();
    chk("drain_ov3", 64'(a_ov), 64'd0);
    chk("drain_occ3", 64'(a_occ), 64'd0);
    // Bubble leaving the last stage must not overwrite its data.
    chk_bus("drain_gate", a_od, beat(300));

    // Async reset mid-stream with a full pipe.
    a_or = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_iv = 1'b1;
      a_id = beat(500 + 100 * i);
      tick();
    end
    a_iv = 1'b0;
    chk("arst_pre_occ", 64'(a_occ), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_ov", 64'(a_ov), 64'd0);
    chk("arst_occ", 64'(a_occ), 64'd0);
    chk_bus("arst_dat", a_od, '0);
    rst = 1'b0;
    a_or = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_post_ov", 64'(a_ov), 64'd0);
      chk("arst_post_occ", 64'(a_occ), 64'd0);
    end

    // Bubble collapse on DEPTH=4: X, two idle cycles, Y, with out_ready low.
    bseq[0] = 32'hAAAA_0001; bseq[1] = 32'hBBBB_0002;
    bseq[2] = 32'hCCCC_0003; bseq[3] = 32'hDDDD_0004;
    b_or = 1'b0;
    b_iv = 1'b1; b_id = bseq[0];
    #1 chk("bub_ir_x", 64'(b_ir), 64'd1);
    tick();
    chk("bub_occ_x", 64'(b_occ), 64'd1);
    b_iv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("bub_ir_idle", 64'(b_ir), 64'd1);
      tick();
      chk("bub_occ_idle", 64'(b_occ), 64'd1);
    end
    b_iv = 1'b1; b_id = bseq[1];
    #1 chk("bub_ir_y", 64'(b_ir), 64'd1);
    tick();
    chk("bub_occ_y", 64'(b_occ), 64'd2);
    chk("bub_ov_y", 64'(b_ov), 64'd1);
    chk("bub_dat_x", 64'(b_od), 64'(bseq[0]));
    b_iv = 1'b0;
    tick();
    tick();
    chk("bub_occ_settle", 64'(b_occ), 64'd2);
    b_iv = 1'b1; b_id = bseq[2];
    #1 chk("bub_ir_z", 64'(b_ir), 64'd1);
    tick();
    chk("bub_occ_z", 64'(b_occ), 64'd3);
    b_id = bseq[3];
    #1 chk("bub_ir_w", 64'(b_ir), 64'd1);
    tick();
    chk("bub_occ_full", 64'(b_occ), 64'd4);
    b_id = 32'hEEEE_0005;
    #1 chk("bub_ir_full", 64'(b_ir), 64'd0);
    b_iv = 1'b0;
    b_or = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bub_drain_ov%0d", i), 64'(b_ov), 64'd1);
      chk($sformatf("bub_drain_dat%0d", i), 64'(b_od), 64'(bseq[i]));
      tick();
    end
    chk("bub_empty_ov", 64'(b_ov), 64'd0);
    chk("bub_empty_occ", 64'(b_occ), 64'd0);

    // Flush on DEPTH=2 with two beats stalled and a beat offered.
    c_or = 1'b0;
    c_iv = 1'b1; c_id = 32'h1111_2222; tick();
    c_id = 32'h3333_4444; tick();
    chk("fl_pre_occ", 64'(c_occ), 64'd2);
    c_id = 32'h5555_6666;
    c_fl = 1'b1;
    #1;
    chk("fl_ir", 64'(c_ir), 64'd0);
    chk("fl_ov_during", 64'(c_ov), 64'd1);
    tick();
    c_fl = 1'b0;
    c_iv = 1'b0;
    chk("fl_occ", 64'(c_occ), 64'd0);
    chk("fl_ov", 64'(c_ov), 64'd0);
    chk("fl_dat_kept", 64'(c_od), 64'h1111_2222);
    c_or = 1'b1;
    #1 chk("fl_ir_after", 64'(c_ir), 64'd1);
    tick();
    chk("fl_no_accept", 64'(c_ov), 64'd0);
    c_iv = 1'b1; c_id = 32'h7777_8888;
    tick();
    c_iv = 1'b0;
    tick();
    chk("fl_resume_ov", 64'(c_ov), 64'd1);
    chk("fl_resume_dat", 64'(c_od), 64'h7777_8888);
    tick();

    // Random traffic on DEPTH=1 against a queue scoreboard.
    seq = 0;
    for (int c = 0; c < 2003; c++) begin
      d_iv = (c < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
      d_or = (c < 2000) ? 1'($urandom_range(0, 1)) : 1'b1;
      d_id = 16'(seq);
      #1;
      chk("rnd_occ_rng", 64'(d_occ <= 2'd1), 64'd1);
      chk("rnd_occ", 64'(d_occ), 64'(q.size()));
      chk("rnd_ov", 64'(d_ov), 64'(q.size() != 0));
      chk("rnd_ir", 64'(d_ir), 64'((q.size() == 0) || d_or));
      if (d_ov && d_or && (q.size() != 0)) begin
        front = q.pop_front();
        chk("rnd_dat", 64'(d_od), 64'(front));
      end
      if (d_iv && d_ir) begin
        q.push_back(d_id);
        seq++;
      end
      tick();
    end
    chk("rnd_loss", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
